accum_nbits: RTL and testbench
==============================

Name: accum_nbits

Overview:
- Sequential accumulator stage that consumes the combinational `adder_nbits` result.
- Sums a programmable-length burst of `bits`-wide pixel samples into an `acc_bits`-wide register.
- Used for per-line and per-window pixel sums in the Level 1 video datapath.
- Valid/ready handshake on input and output; one `adder_nbits` instance in the feedback path.

Parameters:
- bits, 16, width of each input sample.
- acc_bits, 24, accumulator and result width; elaboration error if acc_bits < bits.
- cnt_bits, 8, width of the burst length and of the internal beat counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a burst; honoured only in IDLE.
- len  input  cnt_bits  number of samples in the burst; sampled only on an accepted start.
- d_i  input  bits  sample data.
- d_valid  input  1  d_i is valid.
- d_ready  output  1  block accepts d_i this cycle.
- sum_o  output  acc_bits  burst sum.
- ovf_o  output  1  carry-out occurred during the burst (sticky).
- sum_valid  output  1  sum_o and ovf_o are valid.
- sum_ready  input  1  consumer accepts the result.
- busy  output  1  state is not IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset (rst=1 at a clock edge) sets:
  - state = IDLE
  - acc, cnt, len_q = 0
  - sum_o = 0, ovf_o = 0, sum_valid = 0
  - d_ready = 0 (combinational from state), busy = 0
- A reset mid-burst discards the partial sum; no result is emitted.
- FSM states: IDLE=0, ACCUM=1, DONE=2.
- IDLE:
  - start=1 with len!=0: len_q <= len, acc <= 0, cnt <= 0, ovf_o <= 0, go to ACCUM.
  - start=1 with len==0: sum_o <= 0, ovf_o <= 0, go to DONE. sum_valid=1 in the next cycle.
  - d_valid is ignored.
- ACCUM:
  - d_ready = 1 (combinational: state==ACCUM).
  - A beat is d_valid && d_ready. On each beat: acc <= adder s, ovf_o <= ovf_o | adder c_o, cnt <= cnt+1.
  - On the beat where cnt == len_q-1: sum_o <= new acc value, go to DONE.
  - Latency: sum_valid=1 in the cycle immediately after the final beat.
  - start is ignored.
  - Gaps in d_valid stall the burst with no state change.
- DONE:
  - sum_valid = 1; d_ready = 0; sum_o and ovf_o are held stable.
  - On sum_valid && sum_ready: go to IDLE, sum_valid <= 0.
  - A start in the same cycle as that handshake is ignored.
  - sum_o keeps its last value in IDLE until the next burst completes.
- Adder hookup: a = acc, b = zero-extended d_i, c_i = 0. Width is acc_bits; the combinational path is acc -> adder -> acc.
- Without the optional feature, arithmetic wraps modulo 2^acc_bits.
- busy = (state != IDLE).
- Unused state encoding 3: next state is IDLE, no outputs asserted.

Optional Feature:
- ACC_SAT_EN defined:
  - On a beat with c_o=1, acc <= all-ones and ovf_o <= 1.
  - acc then stays all-ones for the rest of the burst.
- ACC_SAT_EN undefined: acc wraps, and ovf_o still flags the carry.

Decomposition:
- Shared package, also used by later datapath stages:
  - State localparams IDLE/ACCUM/DONE (2-bit).
  - Default widths: SAMPLE_BITS=16, ACC_BITS=24, CNT_BITS=8.
- One sub-module: the existing `adder_nbits`, instantiated with bits=acc_bits. No new sub-module.

Test Plan:
- Basic burst: len=4, samples 1,2,3,4 with d_valid continuous -> 4 beats accepted; sum_o=10 and ovf_o=0 with sum_valid=1 the cycle after the 4th beat; sum_ready=1 -> IDLE, busy=0.
- Zero length: start with len=0 -> sum_valid=1 the next cycle, sum_o=0, no d_ready ever asserted.
- Backpressure:
  - Stimulus: len=3, samples 7,8,9 with a 2-cycle d_valid gap; sum_ready held 0 for 5 cycles; d_valid kept high during DONE.
  - Required: sum_o=24 held stable; d_ready=0; no extra beat accepted.
- Overflow: bits=16, acc_bits=17, len=3, three samples 0xFFFF -> ovf_o=1.
  - Without ACC_SAT_EN: sum_o=0x0FFFD.
  - With ACC_SAT_EN: sum_o=0x1FFFF.
- Reset mid-burst: rst after 2 of 4 beats -> next cycle all outputs 0, state IDLE. Then start len=2, samples 5,6 -> sum_o=11.
- Stray start: start pulse during ACCUM and during the DONE handshake cycle -> ignored; the current burst result is unchanged and the block returns to IDLE.

Source files
------------

// File: rtl/accum_nbits_pkg.sv
// rtl/accum_nbits_pkg.sv - shared FSM states and default widths for the accumulator datapath
package accum_nbits_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int ACC_BITS    = 24;
  localparam int CNT_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_nbits.sv
// rtl/adder_nbits.sv - combinational n-bit adder with carry in and carry out
module adder_nbits #(
  parameter int bits = 16
) (
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  input  logic            c_i,
  output logic [bits-1:0] s,
  output logic            c_o
);

  // full-width sum; the extra top bit becomes the carry out
  always_comb begin
    {c_o, s} = {1'b0, a} + {1'b0, b} + {{bits{1'b0}}, c_i};
  end

endmodule

// File: rtl/accum_nbits.sv
// rtl/accum_nbits.sv - burst accumulator with valid/ready handshakes; ACC_SAT_EN selects saturation
module accum_nbits
  import accum_nbits_pkg::*;
#(
  parameter int bits     = SAMPLE_BITS,
  parameter int acc_bits = ACC_BITS,
  parameter int cnt_bits = CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [cnt_bits-1:0] len,
  input  logic [bits-1:0]     d_i,
  input  logic                d_valid,
  output logic                d_ready,
  output logic [acc_bits-1:0] sum_o,
  output logic                ovf_o,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic                busy
);

  if (acc_bits < bits) begin : g_width_check
    $error("accum_nbits: acc_bits must be >= bits");
  end

  state_t              state;
  logic [acc_bits-1:0] acc;
  logic [acc_bits-1:0] d_ext;
  logic [acc_bits-1:0] add_s;
  logic                add_c;
  logic [acc_bits-1:0] acc_nxt;
  logic [cnt_bits-1:0] cnt;
  logic [cnt_bits-1:0] len_q;
  logic                last_beat;

  adder_nbits #(
    .bits(acc_bits)
  ) u_adder (
    .a   (acc),
    .b   (d_ext),
    .c_i (1'b0),
    .s   (add_s),
    .c_o (add_c)
  );

  // zero-extend the sample and pick wrap or saturate for the next accumulator value
  always_comb begin
    d_ext            = '0;
    d_ext[bits-1:0]  = d_i;
`ifdef ACC_SAT_EN
    acc_nxt = add_c ? {acc_bits{1'b1}} : add_s;
`else
    acc_nxt = add_s;
`endif
  end

  assign last_beat = (cnt == (len_q - cnt_bits'(1)));
  assign d_ready   = (state == ACCUM);
  assign busy      = (state == ACCUM) || (state == DONE);

  // burst control FSM; results and status are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      sum_o     <= '0;
      ovf_o     <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q <= len;
              acc   <= '0;
              cnt   <= '0;
              ovf_o <= 1'b0;
              state <= ACCUM;
            end else begin
              sum_o     <= '0;
              ovf_o     <= 1'b0;
              sum_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (d_valid) begin
            acc   <= acc_nxt;
            ovf_o <= ovf_o | add_c;
            cnt   <= cnt + cnt_bits'(1);
            if (last_beat) begin
              sum_o     <= acc_nxt;
              sum_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          sum_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_nbits.sv
// tb/tb_accum_nbits.sv - scoreboard bench for accum_nbits (bits=16, acc_bits=17)
module tb_accum_nbits;

  localparam int BITS = 16;
  localparam int ACC  = 17;
  localparam int CNT  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CNT-1:0]  len;
  logic [BITS-1:0] d_i;
  logic            d_valid;
  logic            d_ready;
  logic [ACC-1:0]  sum_o;
  logic            ovf_o;
  logic            sum_valid;
  logic            sum_ready;
  logic            busy;

  int passed = 0;
  int total  = 0;
  int beats  = 0;
  logic dr_seen = 1'b0;
  logic [ACC:0] exp_q[$];

`ifdef ACC_SAT_EN
  localparam logic [ACC-1:0] OVF_SUM = 17'h1FFFF;
`else
  localparam logic [ACC-1:0] OVF_SUM = 17'h0FFFD;
`endif

  accum_nbits #(.bits(BITS), .acc_bits(ACC), .cnt_bits(CNT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .d_i       (d_i),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .sum_o     (sum_o),
    .ovf_o     (ovf_o),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // result monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (!rst && d_ready) dr_seen <= 1'b1;
    if (!rst && d_valid && d_ready) beats <= beats + 1;
    if (!rst && sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(sum_o), 32'hFFFF_FFFF);
      end else begin
        logic [ACC:0] e;
        e = exp_q.pop_front();
        check("sum_o", 32'(sum_o), 32'(e[ACC-1:0]));
        check("ovf_o", 32'(ovf_o), 32'(e[ACC]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CNT-1:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [BITS-1:0] v);
    int  t;
    logic done;
    t = 0;
    done = 1'b0;
    d_valid = 1'b1;
    d_i = v;
    while (!done) begin
      @(negedge clk);
      if (d_ready) done = 1'b1;
      step();
      t++;
      if (!done && t > 20) begin
        check("send_timeout", 32'(t), 32'd0);
        done = 1'b1;
      end
    end
    d_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; d_i = '0; d_valid = 1'b0; sum_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_sum_o", 32'(sum_o), 32'd0);
    check("rst_ovf_o", 32'(ovf_o), 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();

    // basic burst 1+2+3+4
    beats = 0;
    exp_q.push_back({1'b0, 17'd10});
    pulse_start(8'd4);
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    @(negedge clk);
    check("basic_latency", 32'(sum_valid), 32'd1);
    step();
    @(negedge clk);
    check("basic_busy_after", 32'(busy), 32'd0);
    check("basic_beats", 32'(beats), 32'd4);
    step();

    // zero length burst
    dr_seen = 1'b0;
    exp_q.push_back({1'b0, 17'd0});
    pulse_start(8'd0);
    @(negedge clk);
    check("zero_sum_valid", 32'(sum_valid), 32'd1);
    step();
    step();
    @(negedge clk);
    check("zero_busy_after", 32'(busy), 32'd0);
    check("zero_no_d_ready", 32'(dr_seen), 32'd0);
    step();

    // backpressure: gap in input, consumer stalls, d_valid held in DONE
    beats = 0;
    sum_ready = 1'b0;
    exp_q.push_back({1'b0, 17'd24});
    pulse_start(8'd3);
    send(16'd7);
    step(); step();
    send(16'd8); send(16'd9);
    d_valid = 1'b1;
    d_i = 16'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum_valid", 32'(sum_valid), 32'd1);
      check("bp_sum_hold", 32'(sum_o), 32'd24);
      check("bp_d_ready", 32'(d_ready), 32'd0);
      step();
    end
    sum_ready = 1'b1;
    step();
    d_valid = 1'b0;
    @(negedge clk);
    check("bp_busy_after", 32'(busy), 32'd0);
    check("bp_beats", 32'(beats), 32'd3);
    check("bp_sum_kept", 32'(sum_o), 32'd24);
    step();

    // overflow: three full-scale samples into a 17-bit accumulator
    exp_q.push_back({1'b1, OVF_SUM});
    pulse_start(8'd3);
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
    @(negedge clk);
    check("ovf_flag", 32'(ovf_o), 32'd1);
    step();

    // reset mid-burst, then a clean burst 5+6
    pulse_start(8'd4);
    send(16'd1); send(16'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_sum_o", 32'(sum_o), 32'd0);
    check("mid_rst_ovf_o", 32'(ovf_o), 32'd0);
    check("mid_rst_sum_valid", 32'(sum_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_d_ready", 32'(d_ready), 32'd0);
    step();
    exp_q.push_back({1'b0, 17'd11});
    pulse_start(8'd2);
    send(16'd5); send(16'd6);
    step();

    // stray starts during ACCUM and on the DONE handshake cycle
    sum_ready = 1'b0;
    exp_q.push_back({1'b0, 17'd7});
    pulse_start(8'd2);
    start = 1'b1;
    len = 8'd0;
    send(16'd3); send(16'd4);
    step();
    len = 8'd1;
    sum_ready = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_sum_kept", 32'(sum_o), 32'd7);
    check("stray_sum_valid", 32'(sum_valid), 32'd0);
    step(); step(); step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
